// File: rtl/rp_acq_pkg.sv
// -----------------------------------------------------------------------------
// rp_acq_pkg
// Shared constants for the acquisition sequencer.
//  - FSM state codes (legacy 3-bit encoding, also exported on state_o)
//  - trigger source code meaning "no source"
// -----------------------------------------------------------------------------
package rp_acq_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRE   = 3'd1;
   localparam logic [2:0] ST_ARMED = 3'd2;
   localparam logic [2:0] ST_POST  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [3:0] TRG_NONE = 4'd0;

endpackage : rp_acq_pkg

// File: rtl/rp_acq_cnt.sv
// -----------------------------------------------------------------------------
// rp_acq_cnt
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
// Ports:
//  adc_clk_i   in   1   clock
//  adc_rstn_i  in   1   asynchronous active-low reset
//  clr_i       in   1   synchronous clear (highest priority)
//  load_i      in   1   load load_val_i
//  load_val_i  in   CW  value to load
//  en_i        in   1   decrement enable (valid sample)
//  cnt_o       out  CW  current count
//  zero_o      out  1   cnt_o == 0
// -----------------------------------------------------------------------------
module rp_acq_cnt
   import rp_acq_pkg::*;
#(
   parameter int CW = 32
) (
   input  logic          adc_clk_i,
   input  logic          adc_rstn_i,
   input  logic          clr_i,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          en_i,
   output logic [CW-1:0] cnt_o,
   output logic          zero_o
);

   assign zero_o = (cnt_o == '0);

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (load_i) begin
         cnt_o <= load_val_i;
      end else if (en_i && !zero_o) begin
         cnt_o <= cnt_o - CW'(1);
      end
   end

endmodule : rp_acq_cnt

// File: rtl/rp_acq_ctrl.sv
// -----------------------------------------------------------------------------
// rp_acq_ctrl
// Per-channel acquisition sequencer around the trigger selector (rp_trig_src).
// Fills the pre-trigger window, hands the pending trigger source to the
// selector once armed, captures the write pointer at trigger and counts the
// post-trigger samples before stopping the buffer writes.
// Ports:
//  adc_clk_i / adc_rstn_i    clock, asynchronous active-low reset
//  arm_i, rst_i              software start / abort pulses
//  set_pre_i, set_dly_i      pre-trigger and post-trigger sample counts
//  set_trg_src_i/_wr_i       requested trigger source and its write strobe
//  dly_valp_i                valid-sample pulse from decimator
//  adc_trig_i                selected trigger from rp_trig_src
//  trg_src_o, trg_new_o      source code and load strobe to the selector
//  trig_dis_clr_o            clear selector trigger-disable (on arm)
//  adc_rst_do_o              acquisition reset pulse
//  adc_dly_do_o              post-trigger delay reached pulse
//  adc_we_o, adc_wp_o        buffer write enable and next write address
//  adc_wp_trig_o             write pointer captured at trigger
//  state_o                   FSM state for the status register
// -----------------------------------------------------------------------------
module rp_acq_ctrl
   import rp_acq_pkg::*;
#(
   parameter int AW = 14,
   parameter int CW = 32
) (
   input  logic          adc_clk_i,
   input  logic          adc_rstn_i,
   input  logic          arm_i,
   input  logic          rst_i,
   input  logic [CW-1:0] set_pre_i,
   input  logic [CW-1:0] set_dly_i,
   input  logic [3:0]    set_trg_src_i,
   input  logic          set_trg_wr_i,
   input  logic          dly_valp_i,
   input  logic          adc_trig_i,
   output logic [3:0]    trg_src_o,
   output logic          trg_new_o,
   output logic          trig_dis_clr_o,
   output logic          adc_rst_do_o,
   output logic          adc_dly_do_o,
   output logic          adc_we_o,
   output logic [AW-1:0] adc_wp_o,
   output logic [AW-1:0] adc_wp_trig_o,
   output logic [2:0]    state_o
);

   logic [CW-1:0] pre_cnt;
   logic [3:0]    pend_src;
   logic          pend_vld;
   logic [CW-1:0] dly_cnt;
   logic          dly_zero;

   logic          pre_done;
   logic          issue;
   logic          trig_hit;
   logic          wr_hit;

   assign pre_done = (state_o == ST_PRE) && (pre_cnt >= set_pre_i);
   // The pending source goes out while armed and also on the very update that
   // enters ARMED, so the selector is loaded before the first armed cycle.
   assign issue    = pend_vld && ((state_o == ST_ARMED) || pre_done);
   assign trig_hit = (state_o == ST_ARMED) && adc_trig_i && !rst_i;
   assign wr_hit   = adc_we_o && dly_valp_i;

   rp_acq_cnt #(.CW(CW)) u_dly_cnt (
      .adc_clk_i  (adc_clk_i),
      .adc_rstn_i (adc_rstn_i),
      .clr_i      (rst_i),
      .load_i     (trig_hit),
      .load_val_i (set_dly_i),
      .en_i       (dly_valp_i && (state_o == ST_POST)),
      .cnt_o      (dly_cnt),
      .zero_o     (dly_zero)
   );

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values; pulses are defaulted low each cycle first.
   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         state_o        <= ST_IDLE;
         pre_cnt        <= '0;
         pend_src       <= TRG_NONE;
         pend_vld       <= 1'b0;
         trg_src_o      <= TRG_NONE;
         trg_new_o      <= 1'b0;
         trig_dis_clr_o <= 1'b0;
         adc_rst_do_o   <= 1'b0;
         adc_dly_do_o   <= 1'b0;
         adc_we_o       <= 1'b0;
         adc_wp_o       <= '0;
         adc_wp_trig_o  <= '0;
      end else begin
         trg_new_o      <= 1'b0;
         trig_dis_clr_o <= 1'b0;
         adc_rst_do_o   <= 1'b0;
         adc_dly_do_o   <= 1'b0;

         if (rst_i) begin
            // Abort wins over everything, including arm, trigger and writes.
            state_o       <= ST_IDLE;
            adc_rst_do_o  <= 1'b1;
            adc_we_o      <= 1'b0;
            adc_wp_o      <= '0;
            adc_wp_trig_o <= '0;
            pre_cnt       <= '0;
            pend_vld      <= 1'b0;
            pend_src      <= TRG_NONE;
         end else begin
            if (wr_hit)
               adc_wp_o <= adc_wp_o + AW'(1);

            if (issue) begin
               trg_src_o <= pend_src;
               trg_new_o <= 1'b1;
               pend_vld  <= 1'b0;
            end
            // Placed after the issue so a write in the issue cycle stays pending.
            if (set_trg_wr_i) begin
               pend_src <= set_trg_src_i;
               pend_vld <= 1'b1;
            end

            case (state_o)
               ST_IDLE, ST_DONE: begin
                  if (arm_i) begin
                     state_o        <= ST_PRE;
                     adc_we_o       <= 1'b1;
                     trig_dis_clr_o <= 1'b1;
                     pre_cnt        <= '0;
                  end
               end
               ST_PRE: begin
                  if (dly_valp_i && (pre_cnt != '1))
                     pre_cnt <= pre_cnt + CW'(1);
                  if (pre_done)
                     state_o <= ST_ARMED;
               end
               ST_ARMED: begin
                  if (adc_trig_i) begin
                     state_o       <= ST_POST;
                     adc_wp_trig_o <= adc_wp_o;
                  end
               end
               ST_POST: begin
                  if (dly_zero) begin
                     state_o      <= ST_DONE;
                     adc_we_o     <= 1'b0;
                     adc_dly_do_o <= 1'b1;
                  end
               end
               default: state_o <= ST_IDLE;
            endcase
         end
      end
   end

endmodule : rp_acq_ctrl

// File: tb/tb_rp_acq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rp_acq_ctrl
// Directed bench for rp_acq_ctrl with a small pointer (AW=4) so wrap-around
// is reached quickly. A cycle table drives the main acquisition, followed by
// hand-written sequences for the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_rp_acq_ctrl;

   localparam int AW = 4;
   localparam int CW = 32;

   logic          adc_clk_i = 1'b0;
   logic          adc_rstn_i;
   logic          arm_i, rst_i, set_trg_wr_i, dly_valp_i, adc_trig_i;
   logic [CW-1:0] set_pre_i, set_dly_i;
   logic [3:0]    set_trg_src_i;
   logic [3:0]    trg_src_o;
   logic          trg_new_o, trig_dis_clr_o, adc_rst_do_o, adc_dly_do_o, adc_we_o;
   logic [AW-1:0] adc_wp_o, adc_wp_trig_o;
   logic [2:0]    state_o;

   int checks = 0;
   int errors = 0;

   always #5 adc_clk_i = ~adc_clk_i;

   rp_acq_ctrl #(.AW(AW), .CW(CW)) dut (
      .adc_clk_i      (adc_clk_i),
      .adc_rstn_i     (adc_rstn_i),
      .arm_i          (arm_i),
      .rst_i          (rst_i),
      .set_pre_i      (set_pre_i),
      .set_dly_i      (set_dly_i),
      .set_trg_src_i  (set_trg_src_i),
      .set_trg_wr_i   (set_trg_wr_i),
      .dly_valp_i     (dly_valp_i),
      .adc_trig_i     (adc_trig_i),
      .trg_src_o      (trg_src_o),
      .trg_new_o      (trg_new_o),
      .trig_dis_clr_o (trig_dis_clr_o),
      .adc_rst_do_o   (adc_rst_do_o),
      .adc_dly_do_o   (adc_dly_do_o),
      .adc_we_o       (adc_we_o),
      .adc_wp_o       (adc_wp_o),
      .adc_wp_trig_o  (adc_wp_trig_o),
      .state_o        (state_o)
   );

   typedef struct {
      logic       arm;
      logic       wr;
      logic [3:0] src;
      logic       trig;
      logic [2:0] e_state;
      logic       e_we;
      logic [3:0] e_wp;
      logic       e_new;
      logic [3:0] e_src;
      logic       e_dly;
      logic       e_clr;
      logic [3:0] e_wpt;
   } vec_t;

   vec_t vec [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic tick();
      @(posedge adc_clk_i);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " trg_src"}, trg_src_o, 0);
      check({tag, " trg_new"}, trg_new_o, 0);
      check({tag, " dis_clr"}, trig_dis_clr_o, 0);
      check({tag, " rst_do"}, adc_rst_do_o, 0);
      check({tag, " dly_do"}, adc_dly_do_o, 0);
      check({tag, " we"}, adc_we_o, 0);
      check({tag, " wp"}, adc_wp_o, 0);
      check({tag, " wp_trig"}, adc_wp_trig_o, 0);
      check({tag, " state"}, state_o, 0);
   endtask

   initial begin
      int         exp_wp;
      int         new_cnt;
      logic [3:0] last_src;

      adc_rstn_i    = 1'b0;
      arm_i         = 1'b0;
      rst_i         = 1'b0;
      set_trg_wr_i  = 1'b0;
      dly_valp_i    = 1'b0;
      adc_trig_i    = 1'b0;
      set_pre_i     = '0;
      set_dly_i     = '0;
      set_trg_src_i = '0;
      #12;
      adc_rstn_i = 1'b1;
      #1;
      check_all_zero("reset");

      // ---------------- main acquisition: pre=4, dly=3, src=6 ----------------
      //           arm wr src trig  st we wp new tsrc dly clr wpt
      vec[0]  = '{0, 1, 6, 0,   0, 0, 0,  0, 0,  0, 0, 0};
      vec[1]  = '{1, 0, 0, 0,   1, 1, 0,  0, 0,  0, 1, 0};
      vec[2]  = '{0, 0, 0, 0,   1, 1, 1,  0, 0,  0, 0, 0};
      vec[3]  = '{0, 0, 0, 0,   1, 1, 2,  0, 0,  0, 0, 0};
      vec[4]  = '{0, 0, 0, 0,   1, 1, 3,  0, 0,  0, 0, 0};
      vec[5]  = '{0, 0, 0, 0,   1, 1, 4,  0, 0,  0, 0, 0};
      vec[6]  = '{0, 0, 0, 0,   2, 1, 5,  1, 6,  0, 0, 0};
      vec[7]  = '{0, 0, 0, 0,   2, 1, 6,  0, 6,  0, 0, 0};
      vec[8]  = '{0, 0, 0, 0,   2, 1, 7,  0, 6,  0, 0, 0};
      vec[9]  = '{0, 0, 0, 1,   3, 1, 8,  0, 6,  0, 0, 7};
      vec[10] = '{0, 0, 0, 0,   3, 1, 9,  0, 6,  0, 0, 7};
      vec[11] = '{0, 0, 0, 0,   3, 1, 10, 0, 6,  0, 0, 7};
      vec[12] = '{0, 0, 0, 0,   3, 1, 11, 0, 6,  0, 0, 7};
      vec[13] = '{0, 0, 0, 0,   4, 0, 12, 0, 6,  1, 0, 7};
      vec[14] = '{0, 0, 0, 0,   4, 0, 12, 0, 6,  0, 0, 7};

      set_pre_i  = 4;
      set_dly_i  = 3;
      dly_valp_i = 1'b1;
      for (int i = 0; i < 15; i++) begin
         arm_i         = vec[i].arm;
         set_trg_wr_i  = vec[i].wr;
         set_trg_src_i = vec[i].src;
         adc_trig_i    = vec[i].trig;
         tick();
         check($sformatf("v%0d state", i), state_o, vec[i].e_state);
         check($sformatf("v%0d we", i), adc_we_o, vec[i].e_we);
         check($sformatf("v%0d wp", i), adc_wp_o, vec[i].e_wp);
         check($sformatf("v%0d trg_new", i), trg_new_o, vec[i].e_new);
         check($sformatf("v%0d trg_src", i), trg_src_o, vec[i].e_src);
         check($sformatf("v%0d dly_do", i), adc_dly_do_o, vec[i].e_dly);
         check($sformatf("v%0d dis_clr", i), trig_dis_clr_o, vec[i].e_clr);
         check($sformatf("v%0d wp_trig", i), adc_wp_trig_o, vec[i].e_wpt);
      end
      arm_i = 0; set_trg_wr_i = 0; adc_trig_i = 0; dly_valp_i = 0;

      // ---------------- pre=0, dly=0: one PRE cycle, immediate done ----------
      set_pre_i = 0;
      set_dly_i = 0;
      arm_i = 1; tick(); arm_i = 0;
      check("z arm state", state_o, 1);
      check("z arm dis_clr", trig_dis_clr_o, 1);
      tick();
      check("z pre1 state", state_o, 2);
      adc_trig_i = 1; tick(); adc_trig_i = 0;
      check("z trig state", state_o, 3);
      check("z wp_trig", adc_wp_trig_o, 12);
      check("z dly_do early", adc_dly_do_o, 0);
      tick();
      check("z done state", state_o, 4);
      check("z dly_do", adc_dly_do_o, 1);
      check("z we off", adc_we_o, 0);
      check("z wp hold", adc_wp_o, 12);

      // ---------------- rst_i together with trigger in ARMED -----------------
      arm_i = 1; tick(); arm_i = 0;
      tick();
      check("r armed", state_o, 2);
      rst_i = 1; adc_trig_i = 1; tick(); rst_i = 0; adc_trig_i = 0;
      check("r state", state_o, 0);
      check("r rst_do", adc_rst_do_o, 1);
      check("r wp", adc_wp_o, 0);
      check("r wp_trig", adc_wp_trig_o, 0);
      check("r we", adc_we_o, 0);
      tick();
      check("r state2", state_o, 0);
      check("r rst_do end", adc_rst_do_o, 0);

      // ---------------- wrap with valid every 3rd cycle ----------------------
      set_pre_i = 100;
      arm_i = 1; tick(); arm_i = 0;
      exp_wp = 0;
      for (int i = 0; i < 60; i++) begin
         dly_valp_i = (i % 3 == 0);
         tick();
         if (i % 3 == 0) exp_wp = (exp_wp + 1) % 16;
         check($sformatf("wrap wp c%0d", i), adc_wp_o, exp_wp);
      end
      dly_valp_i = 0;
      check("wrap final", adc_wp_o, 4);
      rst_i = 1; tick(); rst_i = 0;

      // ---------------- two writes in PRE, arm ignored in POST ---------------
      set_pre_i  = 3;
      set_dly_i  = 1;
      dly_valp_i = 1;
      new_cnt    = 0;
      last_src   = 0;
      arm_i = 1; tick(); arm_i = 0;
      set_trg_wr_i = 1; set_trg_src_i = 2;
      tick();
      if (trg_new_o) begin new_cnt++; last_src = trg_src_o; end
      set_trg_src_i = 9;
      tick();
      if (trg_new_o) begin new_cnt++; last_src = trg_src_o; end
      set_trg_wr_i = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (trg_new_o) begin new_cnt++; last_src = trg_src_o; end
      end
      check("src2x new count", new_cnt, 1);
      check("src2x src", last_src, 9);
      check("src2x armed", state_o, 2);
      adc_trig_i = 1; tick(); adc_trig_i = 0;
      check("post state", state_o, 3);
      arm_i = 1; tick(); arm_i = 0;
      check("post arm ign", state_o, 3);
      check("post arm clr", trig_dis_clr_o, 0);
      tick();
      check("post done", state_o, 4);
      check("post dly_do", adc_dly_do_o, 1);

      // ---------------- async reset in the middle of POST --------------------
      dly_valp_i = 0;
      set_pre_i  = 0;
      set_dly_i  = 10;
      arm_i = 1; tick(); arm_i = 0;
      tick();
      adc_trig_i = 1; tick(); adc_trig_i = 0;
      check("ar in post", state_o, 3);
      check("ar we before", adc_we_o, 1);
      #2;
      adc_rstn_i = 1'b0;
      #1;
      check_all_zero("async");
      #1;
      adc_rstn_i = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rp_acq_ctrl
